// File: rtl/cubehash_ctrl_param_if.sv
// Control/handshake bundle between the CubeHash controller and its neighbours.
// master = controller side, slave = block buffer / datapath / consumer side.
interface cubehash_ctrl_param_if #(
  parameter int BCNT_W = 16
);
  logic              start;
  logic              abort;
  logic              blk_valid;
  logic              blk_last;
  logic              blk_ready;
  logic              load_iv;
  logic              round_en;
  logic              xor_blk;
  logic              xor_fin;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              err;
  logic [BCNT_W-1:0] blk_count;

  modport master (
    input  start, abort, blk_valid, blk_last, out_ready,
    output blk_ready, load_iv, round_en, xor_blk, xor_fin, out_valid, busy, err, blk_count
  );

  modport slave (
    output start, abort, blk_valid, blk_last, out_ready,
    input  blk_ready, load_iv, round_en, xor_blk, xor_fin, out_valid, busy, err, blk_count
  );
endinterface

// File: rtl/cubehash_ctrl_param.sv
// Sequencing FSM for the CubeHash round datapath: IV load, init rounds, block
// absorption, final XOR, final rounds and digest handshake.
module cubehash_ctrl_param #(
  parameter int R      = 16,
  parameter int I_MULT = 10,
  parameter int F_MULT = 10,
  parameter int BCNT_W = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  cubehash_ctrl_param_if.master bus
);
  localparam int MM = (I_MULT > F_MULT) ? I_MULT : F_MULT;
  localparam int RW = (R > 1) ? $clog2(R) : 1;
  localparam int PW = (MM > 1) ? $clog2(MM) : 1;
  localparam logic [RW-1:0] RND_LAST  = RW'(R - 1);
  localparam logic [PW-1:0] INIT_LAST = PW'(I_MULT - 1);
  localparam logic [PW-1:0] FIN_LAST  = PW'(F_MULT - 1);

  typedef enum logic [2:0] {IDLE, INIT, WAIT_BLK, ROUND, FIN_XOR, FINAL, OUT} state_e;

  state_e            state_q;
  logic [RW-1:0]     rnd_q;
  logic [PW-1:0]     rep_q;
  logic              last_q;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              rnd_wrap, in_wait, busy, bad_blk;

  assign rnd_wrap = (rnd_q == RND_LAST);
  assign bcnt_d   = (bcnt_q == '1) ? bcnt_q : bcnt_q + 1'b1;
  assign in_wait  = (state_q == WAIT_BLK);
  assign busy     = (state_q != IDLE);
  assign bad_blk  = state_q inside {ROUND, FIN_XOR, FINAL, OUT};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      rep_q   <= '0;
      last_q  <= 1'b0;
      bcnt_q  <= '0;
    end else if (bus.abort) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      rep_q   <= '0;
      last_q  <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          state_q <= INIT;
          rnd_q   <= '0;
          rep_q   <= '0;
          last_q  <= 1'b0;
          bcnt_q  <= '0;
        end
        INIT: if (rnd_wrap) begin
          rnd_q <= '0;
          if (rep_q == INIT_LAST) begin
            rep_q   <= '0;
            state_q <= WAIT_BLK;
          end else begin
            rep_q <= rep_q + 1'b1;
          end
        end else begin
          rnd_q <= rnd_q + 1'b1;
        end
        WAIT_BLK: if (bus.blk_valid) begin
          last_q  <= bus.blk_last;
          bcnt_q  <= bcnt_d;
          state_q <= ROUND;
        end
        ROUND: if (rnd_wrap) begin
          rnd_q   <= '0;
          state_q <= last_q ? FIN_XOR : WAIT_BLK;
        end else begin
          rnd_q <= rnd_q + 1'b1;
        end
        FIN_XOR: state_q <= FINAL;
        FINAL: if (rnd_wrap) begin
          rnd_q <= '0;
          if (rep_q == FIN_LAST) begin
            rep_q   <= '0;
            state_q <= OUT;
          end else begin
            rep_q <= rep_q + 1'b1;
          end
        end else begin
          rnd_q <= rnd_q + 1'b1;
        end
        OUT: if (bus.out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // abort suppresses every strobe and error in its cycle; level outputs follow state
  assign bus.busy      = busy;
  assign bus.blk_ready = in_wait;
  assign bus.out_valid = (state_q == OUT);
  assign bus.blk_count = bcnt_q;
  assign bus.round_en  = !bus.abort && (state_q inside {INIT, ROUND, FINAL});
  assign bus.xor_fin   = !bus.abort && (state_q == FIN_XOR);
  assign bus.load_iv   = rst_n && !bus.abort && (state_q == IDLE) && bus.start;
  assign bus.xor_blk   = !bus.abort && in_wait && bus.blk_valid;
  assign bus.err       = !bus.abort && ((bus.start && busy) ||
                                        (bus.blk_valid && bad_blk) ||
                                        (bus.blk_last && !bus.blk_valid && in_wait));
endmodule

// File: tb/tb_cubehash_ctrl_param.sv
// Bench for cubehash_ctrl_param: default-parameter and small-parameter instances,
// a per-cycle vector table, an interval-based message model and hand corner cases.
module tb_cubehash_ctrl_param;
  localparam int R0 = 16, I0 = 10, F0 = 10, W0 = 16;
  localparam int R1 = 2,  I1 = 1,  F1 = 3,  W1 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cubehash_ctrl_param_if #(.BCNT_W(W0)) b0 ();
  cubehash_ctrl_param_if #(.BCNT_W(W1)) b1 ();

  cubehash_ctrl_param #(.R(R0), .I_MULT(I0), .F_MULT(F0), .BCNT_W(W0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  cubehash_ctrl_param #(.R(R1), .I_MULT(I1), .F_MULT(F1), .BCNT_W(W1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));

  typedef struct packed {
    logic start, abort, valid, last, ordy;
  } in_t;

  typedef struct packed {
    logic        load_iv, round_en, xor_blk, xor_fin, blk_ready, out_valid, busy, err;
    logic [15:0] cnt;
  } out_t;

  typedef struct packed {
    in_t         i;
    logic [7:0]  o;
    logic [15:0] c;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input int sel, input in_t v);
    if (sel == 0) begin
      b0.start = v.start; b0.abort = v.abort; b0.blk_valid = v.valid;
      b0.blk_last = v.last; b0.out_ready = v.ordy;
    end else begin
      b1.start = v.start; b1.abort = v.abort; b1.blk_valid = v.valid;
      b1.blk_last = v.last; b1.out_ready = v.ordy;
    end
  endtask

  function automatic out_t sample(input int sel);
    out_t o;
    if (sel == 0) begin
      o.load_iv = b0.load_iv; o.round_en = b0.round_en; o.xor_blk = b0.xor_blk;
      o.xor_fin = b0.xor_fin; o.blk_ready = b0.blk_ready; o.out_valid = b0.out_valid;
      o.busy = b0.busy; o.err = b0.err; o.cnt = 16'(b0.blk_count);
    end else begin
      o.load_iv = b1.load_iv; o.round_en = b1.round_en; o.xor_blk = b1.xor_blk;
      o.xor_fin = b1.xor_fin; o.blk_ready = b1.blk_ready; o.out_valid = b1.out_valid;
      o.busy = b1.busy; o.err = b1.err; o.cnt = 16'(b1.blk_count);
    end
    return o;
  endfunction

  // Called at posedge+1: apply inputs, sample on the falling edge, advance one clock.
  task automatic cyc(input int sel, input in_t v, output out_t o);
    drive(sel, v);
    @(negedge clk);
    o = sample(sel);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [4:0] i, input logic [7:0] o, input int c);
    vec_t t;
    t.i = in_t'(i);
    t.o = o;
    t.c = 16'(c);
    return t;
  endfunction

  // Expected timeline from the cycle budget of each phase: start at cycle 0, init
  // rounds, per-block wait windows and R-round bursts, final XOR, final rounds, OUT.
  task automatic run_msg(input int sel, input int n, input int gap[$], input int dly,
                         input bit noise, inout int pcnt,
                         output int n_re, output int n_xb, output int n_xf,
                         output int t_xf, output int t_ov, output int t_rdy);
    int rr, ir, fr, cmax, tf, o, e, w;
    int a[$];
    int ws[$];
    rr   = sel ? R1 : R0;
    ir   = (sel ? I1 : I0) * rr;
    fr   = (sel ? F1 : F0) * rr;
    cmax = sel ? 3 : 65535;
    w = ir + 1;
    for (int k = 0; k < n; k++) begin
      ws.push_back(w);
      a.push_back(w + gap[k]);
      w = a[k] + rr + 1;
    end
    tf = a[n-1] + rr + 1;
    o  = tf + 1 + fr;
    e  = o + dly;
    n_re = 0; n_xb = 0; n_xf = 0; t_xf = -1; t_ov = -1; t_rdy = -1;
    for (int c = 0; c <= e + 1; c++) begin
      in_t  v;
      out_t x, g;
      bit   init, rdy, acc, rnd, bsy;
      int   nacc, kacc;
      init = (c >= 1) && (c <= ir);
      rdy = 0; acc = 0; rnd = init; nacc = 0; kacc = 0;
      for (int k = 0; k < n; k++) begin
        if (c >= ws[k] && c <= a[k]) rdy = 1;
        if (c == a[k]) begin acc = 1; kacc = k; end
        if (c > a[k] && c <= a[k] + rr) rnd = 1;
        if (a[k] < c) nacc++;
      end
      if (c > tf && c <= tf + fr) rnd = 1;
      bsy = (c >= 1) && (c <= e);
      v = '0;
      v.start = (c == 0) || (noise && bsy && $urandom_range(15) == 0);
      v.valid = acc || (noise && bsy && !rdy && $urandom_range(3) == 0);
      v.last  = acc ? (kacc == n - 1) : (noise && $urandom_range(3) == 0);
      v.ordy  = (c == e) || (noise && !(c >= o && c <= e) && $urandom_range(3) == 0);
      x = '0;
      x.load_iv   = (c == 0);
      x.round_en  = rnd;
      x.xor_blk   = acc;
      x.xor_fin   = (c == tf);
      x.blk_ready = rdy;
      x.out_valid = (c >= o) && (c <= e);
      x.busy      = bsy;
      x.err       = (v.start && bsy) || (v.valid && bsy && !rdy && !init) ||
                    (v.last && !v.valid && rdy);
      x.cnt       = 16'((c == 0) ? pcnt : ((nacc < cmax) ? nacc : cmax));
      cyc(sel, v, g);
      chk($sformatf("cycle sel=%0d c=%0d", sel, c), 64'(g), 64'(x));
      n_re += int'(g.round_en);
      n_xb += int'(g.xor_blk);
      n_xf += int'(g.xor_fin);
      if (g.xor_fin && t_xf < 0) t_xf = c;
      if (g.out_valid && t_ov < 0) t_ov = c;
      if (g.blk_ready && t_rdy < 0) t_rdy = c;
    end
    pcnt = (n < cmax) ? n : cmax;
  endtask

  initial begin
    vec_t tbl[$];
    out_t g;
    in_t  idle;
    int   pc0, pc1, n_re, n_xb, n_xf, t_xf, t_ov, t_rdy, n, dly;
    int   gaps[$];

    idle = '0;
    pc0 = 0; pc1 = 0;

    // Small instance, one cycle per row: {start,abort,valid,last,ordy},
    // {load_iv,round_en,xor_blk,xor_fin,blk_ready,out_valid,busy,err}, blk_count
    tbl.push_back(mk(5'b10000, 8'b10000000, 0));
    tbl.push_back(mk(5'b10000, 8'b01000011, 0));
    tbl.push_back(mk(5'b00010, 8'b01000010, 0));
    tbl.push_back(mk(5'b00000, 8'b00001010, 0));
    tbl.push_back(mk(5'b00010, 8'b00001011, 0));
    tbl.push_back(mk(5'b00100, 8'b00101010, 0));
    tbl.push_back(mk(5'b00100, 8'b01000011, 1));
    tbl.push_back(mk(5'b00000, 8'b01000010, 1));
    tbl.push_back(mk(5'b00110, 8'b00101010, 1));
    tbl.push_back(mk(5'b00000, 8'b01000010, 2));
    tbl.push_back(mk(5'b00001, 8'b01000010, 2));
    tbl.push_back(mk(5'b00100, 8'b00010011, 2));
    for (int k = 0; k < 6; k++) tbl.push_back(mk(5'b00000, 8'b01000010, 2));
    tbl.push_back(mk(5'b00000, 8'b00000110, 2));
    tbl.push_back(mk(5'b10001, 8'b00000111, 2));
    tbl.push_back(mk(5'b00000, 8'b00000000, 2));
    tbl.push_back(mk(5'b10000, 8'b10000000, 2));
    tbl.push_back(mk(5'b01000, 8'b00000010, 0));
    tbl.push_back(mk(5'b00000, 8'b00000000, 0));

    // Reset held: outputs must be 0 even with start asserted
    drive(0, in_t'(5'b10000));
    drive(1, in_t'(5'b10000));
    @(negedge clk);
    chk("reset0", 64'(sample(0)), 64'(0));
    chk("reset1", 64'(sample(1)), 64'(0));
    drive(0, idle);
    drive(1, idle);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      cyc(1, tbl[k].i, g);
      chk($sformatf("tbl%0d flags", k), 64'({g.load_iv, g.round_en, g.xor_blk, g.xor_fin,
                                            g.blk_ready, g.out_valid, g.busy, g.err}), 64'(tbl[k].o));
      chk($sformatf("tbl%0d cnt", k), 64'(g.cnt), 64'(tbl[k].c));
    end

    // Defaults, single last block at first blk_ready
    gaps = '{0};
    run_msg(0, 1, gaps, 2, 1'b0, pc0, n_re, n_xb, n_xf, t_xf, t_ov, t_rdy);
    chk("def rounds", 64'(n_re), 64'(336));
    chk("def xor_fin count", 64'(n_xf), 64'(1));
    chk("def xor_fin cycle", 64'(t_xf), 64'(178));
    chk("def out_valid cycle", 64'(t_ov), 64'(339));
    chk("def first ready", 64'(t_rdy), 64'(161));
    chk("def blk_count", 64'(b0.blk_count), 64'(1));

    // out_ready withheld for 20 cycles
    run_msg(0, 1, gaps, 20, 1'b0, pc0, n_re, n_xb, n_xf, t_xf, t_ov, t_rdy);
    chk("hold out_valid cycle", 64'(t_ov), 64'(339));

    // Three blocks, gaps 0/5/0
    gaps = '{0, 5, 0};
    run_msg(0, 3, gaps, 1, 1'b0, pc0, n_re, n_xb, n_xf, t_xf, t_ov, t_rdy);
    chk("3blk xor_blk", 64'(n_xb), 64'(3));
    chk("3blk blk_count", 64'(b0.blk_count), 64'(3));

    // Small parameters: ready 3 cycles after start, out_valid 10 after last block
    gaps = '{0};
    run_msg(1, 1, gaps, 0, 1'b0, pc1, n_re, n_xb, n_xf, t_xf, t_ov, t_rdy);
    chk("small ready", 64'(t_rdy), 64'(3));
    chk("small out_valid", 64'(t_ov), 64'(13));
    chk("small rounds", 64'(n_re), 64'(2 + 2 + 6));

    // Randomized messages with protocol-noise inputs
    for (int it = 0; it < 24; it++) begin
      n = $urandom_range(5, 1);
      dly = $urandom_range(4);
      gaps = {};
      for (int k = 0; k < n; k++) gaps.push_back($urandom_range(4));
      run_msg(1, n, gaps, dly, 1'b1, pc1, n_re, n_xb, n_xf, t_xf, t_ov, t_rdy);
    end
    for (int it = 0; it < 2; it++) begin
      n = $urandom_range(3, 1);
      gaps = {};
      for (int k = 0; k < n; k++) gaps.push_back($urandom_range(3));
      run_msg(0, n, gaps, $urandom_range(3), 1'b1, pc0, n_re, n_xb, n_xf, t_xf, t_ov, t_rdy);
    end

    // Abort in ROUND at rnd=7 together with blk_valid
    cyc(0, in_t'(5'b10000), g);
    for (int c = 1; c < 169; c++) cyc(0, (c == 161) ? in_t'(5'b00100) : idle, g);
    cyc(0, in_t'(5'b01100), g);
    chk("abort cycle", 64'(g), 64'({8'b00000010, 16'd1}));
    cyc(0, idle, g);
    chk("after abort", 64'(g), 64'(0));

    // Asynchronous reset mid-FINAL
    cyc(0, in_t'(5'b10000), g);
    for (int c = 1; c < 200; c++) cyc(0, (c == 161) ? in_t'(5'b00110) : idle, g);
    drive(0, idle);
    #1;
    g = sample(0);
    chk("final before reset", 64'(g), 64'({8'b01000010, 16'd1}));
    rst_n = 1'b0;
    #1;
    chk("async reset", 64'(sample(0)), 64'(0));
    @(negedge clk);
    chk("reset held", 64'(sample(0)), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, idle, g);
    chk("idle after reset", 64'(g), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
